// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall/flush, control-register file, MEM-stage exception/EXRT/WRCR sequencing.
// Latency: stall, flush, new_pc and creg_rd_data are combinational; register updates land on the next clk edge.
// Backpressure: if_busy/mem_busy stall every stage and block all flushes and register updates.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   creg_rd_addr/_data    control-register read port for the decoder (combinational)
//   exe_mode, int_detect  current privilege mode, unmasked interrupt pending
//   irq                   level-sensitive external interrupt lines
//   if_busy, mem_busy     bus wait inputs; ld_hazard load-use hazard from decoder
//   mem_*                 MEM-stage instruction: valid, word PC, ctrl op, WRCR target/data, exception code
//   *_stall, *_flush      per-stage pipeline control
//   new_pc                redirect target, meaningful while if_flush is set
module pipe_ctrl #(
   parameter int IRQ_W = 8,
   parameter int EXP_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       creg_rd_addr,
   output logic [31:0]      creg_rd_data,
   output logic             exe_mode,
   input  logic [IRQ_W-1:0] irq,
   output logic             int_detect,
   input  logic             if_busy,
   input  logic             mem_busy,
   input  logic             ld_hazard,
   input  logic             mem_en,
   input  logic [29:0]      mem_pc,
   input  logic [1:0]       mem_ctrl_op,
   input  logic [4:0]       mem_dst_addr,
   input  logic [EXP_W-1:0] mem_exp_code,
   input  logic [31:0]      mem_out,
   output logic             if_stall,
   output logic             id_stall,
   output logic             ex_stall,
   output logic             mem_stall,
   output logic             if_flush,
   output logic             id_flush,
   output logic             ex_flush,
   output logic             mem_flush,
   output logic [29:0]      new_pc
);

   localparam logic [1:0]       OP_WRCR  = 2'd1;
   localparam logic [1:0]       OP_EXRT  = 2'd2;
   localparam logic [EXP_W-1:0] EXP_TRAP = EXP_W'(5);

   // status/pre_status layout: bit1 int_en, bit0 exe_mode
   logic [1:0]       status;
   logic [1:0]       pre_status;
   logic [29:0]      exp_vector;
   logic [EXP_W-1:0] cause;
   logic [IRQ_W-1:0] int_mask;
   logic [29:0]      epc;

   logic stall;
   logic ev_ok;
   logic take_exp;
   logic take_exrt;
   logic take_wrcr;
   logic flush_all;

   // Only one MEM-stage event can be taken per cycle; exception beats EXRT beats WRCR.
   always_comb begin
      stall     = if_busy | mem_busy;
      ev_ok     = mem_en & ~stall;
      take_exp  = ev_ok & (mem_exp_code != '0);
      take_exrt = ev_ok & ~take_exp & (mem_ctrl_op == OP_EXRT);
      take_wrcr = ev_ok & ~take_exp & (mem_ctrl_op == OP_WRCR);
      flush_all = take_exp | take_exrt | take_wrcr;
   end

   always_comb begin
      if_stall  = stall | ld_hazard;
      id_stall  = stall;
      ex_stall  = stall;
      mem_stall = stall;

      if_flush  = flush_all;
      // A load-use bubble is inserted into ID, but not while the pipe is frozen.
      id_flush  = flush_all | (~stall & ld_hazard);
      ex_flush  = flush_all;
      mem_flush = flush_all;

      new_pc = '0;
      if (take_exp)
         new_pc = exp_vector;
      else if (take_exrt)
         new_pc = epc;
      else if (take_wrcr)
         new_pc = mem_pc + 30'd1;
   end

   always_comb begin
      exe_mode   = status[0];
      int_detect = status[1] & (|(irq & ~int_mask));
   end

   always_comb begin
      creg_rd_data = '0;
      case (creg_rd_addr)
         5'd0:    creg_rd_data = {30'd0, status};
         5'd1:    creg_rd_data = {30'd0, pre_status};
         5'd2:    creg_rd_data = {mem_pc, 2'b00};
         5'd3:    creg_rd_data = {exp_vector, 2'b00};
         5'd4:    creg_rd_data = 32'(cause);
         5'd5:    creg_rd_data = 32'(int_mask);
         5'd6:    creg_rd_data = 32'(irq);
         5'd7:    creg_rd_data = {epc, 2'b00};
         default: creg_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status     <= '0;
         pre_status <= '0;
         exp_vector <= '0;
         cause      <= '0;
         int_mask   <= '0;
         epc        <= '0;
      end else if (take_exp) begin
         pre_status <= status;
         status     <= 2'b00;
         cause      <= mem_exp_code;
         // TRAP returns past the trapping instruction; faults re-execute it.
         epc        <= (mem_exp_code == EXP_TRAP) ? mem_pc + 30'd1 : mem_pc;
      end else if (take_exrt) begin
         status <= pre_status;
      end else if (take_wrcr) begin
         case (mem_dst_addr)
            5'd0:    status     <= mem_out[1:0];
            5'd1:    pre_status <= mem_out[1:0];
            5'd3:    exp_vector <= mem_out[31:2];
            5'd5:    int_mask   <= mem_out[IRQ_W-1:0];
            5'd7:    epc        <= mem_out[31:2];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  creg_rd_addr;
   logic [31:0] creg_rd_data;
   logic        exe_mode;
   logic [7:0]  irq;
   logic        int_detect;
   logic        if_busy, mem_busy, ld_hazard, mem_en;
   logic [29:0] mem_pc;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;
   logic [29:0] new_pc;

   pipe_ctrl #(.IRQ_W(8), .EXP_W(3)) dut (
      .clk(clk), .reset(reset),
      .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
      .exe_mode(exe_mode), .irq(irq), .int_detect(int_detect),
      .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
      .mem_en(mem_en), .mem_pc(mem_pc), .mem_ctrl_op(mem_ctrl_op),
      .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code), .mem_out(mem_out),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
      .new_pc(new_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        em;
      logic        intd;
      logic [3:0]  stl;   // {if,id,ex,mem}
      logic [3:0]  fl;    // {if,id,ex,mem}
      logic [29:0] npc;
      bit          chk_npc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   npc_idle_chk = 0;

   // Reference model: the eight architectural control registers as 32-bit read views.
   logic [31:0] cr [8];

   function automatic logic [31:0] wmask(int a);
      case (a)
         0, 1:    return 32'h0000_0003;
         3, 7:    return 32'hFFFF_FFFC;
         5:       return 32'h0000_00FF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(logic [4:0] a);
      if (a == 5'd2) return {mem_pc, 2'b00};
      if (a == 5'd6) return {24'd0, irq};
      if (a < 5'd8)  return cr[a[2:0]];
      return 32'h0;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      n_chk++;
      if (act !== expv)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
      else
         n_pass++;
   endtask

   // Monitor: outputs are combinational, so each cycle the DUT presents one response.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("creg_rd_data", creg_rd_data, e.rd);
         chk("exe_mode", {31'd0, exe_mode}, {31'd0, e.em});
         chk("int_detect", {31'd0, int_detect}, {31'd0, e.intd});
         chk("stalls", {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, e.stl});
         chk("flushes", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, e.fl});
         if (e.chk_npc) chk("new_pc", {2'd0, new_pc}, {2'd0, e.npc});
      end
   end

   // Predict this cycle's outputs, hand them to the monitor, then advance the model at the edge.
   task automatic step();
      exp_t e;
      bit   busy;
      int   ev;          // 0 none, 1 exception, 2 EXRT, 3 WRCR
      logic [29:0] pc1;
      busy = if_busy || mem_busy;
      ev = 0;
      if (!busy && mem_en) begin
         if (mem_exp_code != 0) ev = 1;
         else if (mem_ctrl_op == 2) ev = 2;
         else if (mem_ctrl_op == 1) ev = 3;
      end
      pc1 = mem_pc + 30'd1;
      e.rd   = m_read(creg_rd_addr);
      e.em   = cr[0][0];
      e.intd = cr[0][1] && ((irq & ~cr[5][7:0]) != 8'h00);
      e.stl  = busy ? 4'b1111 : (ld_hazard ? 4'b1000 : 4'b0000);
      e.fl   = (ev != 0) ? 4'b1111 : ((!busy && ld_hazard) ? 4'b0100 : 4'b0000);
      case (ev)
         1:       e.npc = cr[3][31:2];
         2:       e.npc = cr[7][31:2];
         3:       e.npc = pc1;
         default: e.npc = 30'd0;
      endcase
      e.chk_npc = (ev != 0) || npc_idle_chk;
      sb.push_back(e);
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) cr[i] = 32'h0;
      end else if (ev == 1) begin
         cr[1] = cr[0];
         cr[0] = 32'h0;
         cr[4] = {29'd0, mem_exp_code};
         cr[7] = {(mem_exp_code == 3'd5) ? pc1 : mem_pc, 2'b00};
      end else if (ev == 2) begin
         cr[0] = cr[1];
      end else if (ev == 3) begin
         if (mem_dst_addr < 5'd8)
            cr[mem_dst_addr[2:0]] = (cr[mem_dst_addr[2:0]] & ~wmask(int'(mem_dst_addr)))
                                  | (mem_out & wmask(int'(mem_dst_addr)));
      end
      #1;
   endtask

   task automatic idle();
      if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0;
      mem_ctrl_op = 0; mem_exp_code = 0; mem_dst_addr = 0; mem_out = 0;
   endtask

   task automatic wrcr(logic [4:0] a, logic [31:0] d, logic [29:0] pc);
      idle(); mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = a; mem_out = d; mem_pc = pc;
      step();
   endtask

   task automatic rd(logic [4:0] a);
      idle(); creg_rd_addr = a; step();
   endtask

   initial begin
      reset = 1; irq = 0; mem_pc = 0; creg_rd_addr = 0;
      idle();
      for (int i = 0; i < 8; i++) cr[i] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;

      // Reset state and stall/hazard behaviour
      npc_idle_chk = 1;
      rd(5'd0);
      npc_idle_chk = 0;
      idle(); if_busy = 1; step();
      idle(); ld_hazard = 1; step();
      idle(); ld_hazard = 1; mem_busy = 1; step();

      // Vector setup, enable interrupts in user mode, then TRAP
      wrcr(5'd3, 32'h0000_0100, 30'h10);
      wrcr(5'd0, 32'h0000_0003, 30'h11);
      idle(); mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h40; creg_rd_addr = 5'd0; step();
      rd(5'd7); rd(5'd4); rd(5'd0); rd(5'd1); rd(5'd2); rd(5'd3);

      // EXRT restores the pre-exception status
      idle(); mem_en = 1; mem_ctrl_op = 2'd2; mem_pc = 30'h99; step();
      rd(5'd0); rd(5'd0);

      // Interrupt masking
      wrcr(5'd5, 32'hFFFF_FFFE, 30'h3FFF_FFFF);   // also exercises new_pc wrap
      idle(); irq = 8'h01; creg_rd_addr = 5'd6; step();
      idle(); irq = 8'h02; step();
      rd(5'd5);

      // Exception held off by a MEM bus wait, then taken
      idle(); mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h77; mem_busy = 1; creg_rd_addr = 5'd4; step();
      rd(5'd4);
      idle(); mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h77; creg_rd_addr = 5'd7; step();
      rd(5'd7); rd(5'd1);

      // mem_en=0 ignores the MEM-stage event; unimplemented/RO targets ignore writes
      idle(); mem_exp_code = 3'd4; mem_ctrl_op = 2'd1; step();
      wrcr(5'd4, 32'hFFFF_FFFF, 30'h5);
      wrcr(5'd9, 32'hFFFF_FFFF, 30'h5);
      rd(5'd4); rd(5'd9);

      // Reset beats a simultaneous WRCR
      reset = 1; wrcr(5'd3, 32'hFFFF_F000, 30'h8);
      reset = 0; rd(5'd3);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 199) == 0);
         irq          = 8'($urandom);
         if_busy      = ($urandom_range(0, 9) == 0);
         mem_busy     = ($urandom_range(0, 9) == 0);
         ld_hazard    = ($urandom_range(0, 5) == 0);
         mem_en       = ($urandom_range(0, 3) != 0);
         mem_pc       = 30'($urandom);
         mem_ctrl_op  = 2'($urandom);
         mem_exp_code = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
         mem_dst_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         mem_out      = $urandom;
         creg_rd_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         step();
      end
      reset = 0;
      idle();

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      if (sb.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d responses left unchecked, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
